// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory responder: state encoding, widths
// and default timing parameters.
package mem_if_pkg;

  localparam int WORD_W        = 32;
  localparam int CNT_W         = 8;
  localparam int DEF_ADDR_BITS = 10;
  localparam int DEF_LATENCY   = 3;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] WAIT = 2'b01;
  localparam logic [1:0] RESP = 2'b10;

  typedef logic [WORD_W-1:0] word_t;

  // Counter preload: the access happens on the edge where the counter reads zero.
  function automatic logic [CNT_W-1:0] cnt_init(input int latency);
    return CNT_W'(latency - 1);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 2**ADDR_BITS x 32, registered read data.
// rdata only changes on a read access and clears on reset; contents never reset.
module mem_array
  import mem_if_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: answers held mem_read/mem_write with a one-cycle
// mem_ready LATENCY edges after the request is sampled; requests ignored while busy.
module mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [WORD_W-1:0] mem_data_out,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              mem_ready,
  output logic              busy,
  output logic              protocol_err
);

  localparam logic [CNT_W-1:0] CNT_INIT = cnt_init(LATENCY);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("mem_responder: LATENCY must be in 1..255");
  end

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic                 op_write;
  logic [ADDR_BITS-1:0] idx;
  logic [WORD_W-1:0]    wdata_q;
  logic                 ready_q;
  logic                 perr_q;
  logic                 req;
  logic                 access;
  logic                 unused_addr_bits;

  assign req = mem_read | mem_write;

  // A reset on the access edge must suppress the array write.
  assign access = (state == WAIT) && (cnt == '0) && !rst;

  // High address bits alias; the low two select a byte within the word.
  assign unused_addr_bits = ^{mem_address[31:ADDR_BITS+2], mem_address[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          if (req) begin
            op_write <= mem_write & ~mem_read;
            idx      <= mem_address[ADDR_BITS+1:2];
            wdata_q  <= mem_data_out;
            cnt      <= CNT_INIT;
            state    <= WAIT;
            if (mem_read && mem_write) begin
              perr_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            ready_q <= 1'b1;
            state   <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .en    (access),
    .we    (op_write),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (mem_data_in)
  );

  assign mem_ready    = ready_q;
  assign busy         = (state == WAIT) || (state == RESP);
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (LATENCY=3, ADDR_BITS=10).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_ready;
  logic        busy;
  logic        protocol_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS(10),
    .LATENCY  (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in),
    .mem_ready    (mem_ready),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until mem_ready is seen; the first counted edge samples the request.
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!mem_ready && n < 200);
    if (!mem_ready) check("ready_timeout", {31'b0, mem_ready}, 32'd1);
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, output int n);
    mem_read     = rd;
    mem_write    = wr;
    mem_address  = addr;
    mem_data_out = wdata;
    wait_ready(n);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    tick();
    check("ready_one_cycle", {31'b0, mem_ready}, 32'd0);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_data_out = '0;
    tick();
    tick();
    check("rst_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_perr", {31'b0, protocol_err}, 32'd0);
    check("rst_data", mem_data_in, 32'h0);
    rst = 1'b0;
    tick();

    // Write then read with cycle-exact ready/busy
    mem_write    = 1'b1;
    mem_address  = 32'h0000_0104;
    mem_data_out = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t1_ready_e%0d", i), {31'b0, mem_ready}, {31'b0, (i == 3)});
      check($sformatf("t1_busy_e%0d", i), {31'b0, busy}, {31'b0, (i < 4)});
      if (i == 3) mem_write = 1'b0;
    end
    check("t1_data_unchanged_by_write", mem_data_in, 32'h0);
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, n);
    check("t1_read_latency", n, 32'd4);
    check("t1_read_data", mem_data_in, 32'hDEAD_BEEF);

    // Back-to-back write-back then allocate
    txn(1'b0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, n);
    mem_write    = 1'b1;
    mem_address  = 32'h0000_0010;
    mem_data_out = 32'h1122_3344;
    wait_ready(n);
    mem_write    = 1'b0;
    mem_read     = 1'b1;
    mem_address  = 32'h0000_0020;
    mem_data_out = 32'hFFFF_FFFF;
    wait_ready(n);
    check("t2_gap_edges", n, 32'd5);
    check("t2_alloc_data", mem_data_in, 32'hA5A5_A5A5);
    mem_read = 1'b0;
    tick();
    txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, n);
    check("t2_wb_data", mem_data_in, 32'h1122_3344);

    // Address aliasing above the index bits
    txn(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, n);
    txn(1'b1, 1'b0, 32'hFFFF_F008, 32'h0, n);
    check("t3_alias_data", mem_data_in, 32'hCAFE_F00D);

    // Simultaneous read and write: read wins, error is sticky
    txn(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, n);
    check("t4_perr_before", {31'b0, protocol_err}, 32'd0);
    txn(1'b1, 1'b1, 32'h0000_0040, 32'h9999_9999, n);
    check("t4_both_read_data", mem_data_in, 32'h1234_5678);
    check("t4_perr_set", {31'b0, protocol_err}, 32'd1);
    txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, n);
    check("t4_store_unchanged", mem_data_in, 32'h1234_5678);
    check("t4_perr_sticky", {31'b0, protocol_err}, 32'd1);

    // Reset in the middle of a write
    txn(1'b0, 1'b1, 32'h0000_0080, 32'h7777_7777, n);
    mem_write    = 1'b1;
    mem_address  = 32'h0000_0080;
    mem_data_out = 32'h5555_5555;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_ready_after_rst", {31'b0, mem_ready}, 32'd0);
    check("t5_busy_after_rst", {31'b0, busy}, 32'd0);
    check("t5_perr_cleared", {31'b0, protocol_err}, 32'd0);
    rst       = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t5_no_ready_%0d", i), {31'b0, mem_ready}, 32'd0);
    end
    txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, n);
    check("t5_prior_contents", mem_data_in, 32'h7777_7777);

    // Input churn during WAIT must not affect the latched request
    mem_write    = 1'b1;
    mem_address  = 32'h0000_00C0;
    mem_data_out = 32'h0F0F_0F0F;
    tick();
    for (int i = 0; i < 3 && !mem_ready; i++) begin
      mem_address  = (i % 2 == 0) ? 32'h0000_0104 : 32'h0000_0008;
      mem_data_out = $urandom;
      mem_read     = (i == 1);
      tick();
    end
    check("t6_ready", {31'b0, mem_ready}, 32'd1);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    tick();
    txn(1'b1, 1'b0, 32'h0000_00C0, 32'h0, n);
    check("t6_latched_data", mem_data_in, 32'h0F0F_0F0F);
    txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, n);
    check("t6_other_idx_a", mem_data_in, 32'hDEAD_BEEF);
    txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, n);
    check("t6_other_idx_b", mem_data_in, 32'hCAFE_F00D);

    // Request dropped during WAIT still completes
    mem_write    = 1'b1;
    mem_address  = 32'h0000_0300;
    mem_data_out = 32'h1357_2468;
    tick();
    mem_write = 1'b0;
    wait_ready(n);
    check("t7_drop_latency", n, 32'd3);
    tick();
    txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, n);
    check("t7_drop_data", mem_data_in, 32'h1357_2468);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
